// File: rtl/vend_controller_if.sv
// Coin-acceptor and actuator handshake bundle for the vending controller.
// The slave side is the controller; the master side is its environment.
interface vend_controller_if #(
   parameter int CREDIT_W = 6
);
   logic                fiveRupees;
   logic                tenRupees;
   logic                twentyFiveRupees;
   logic                cancel;
   logic                dispenseDone;
   logic                changeAck;
   logic                dispenseReq;
   logic                changeReq;
   logic                coinReject;
   logic [CREDIT_W-1:0] credit;
   logic                busy;

   modport master (
      output fiveRupees, tenRupees, twentyFiveRupees, cancel, dispenseDone, changeAck,
      input  dispenseReq, changeReq, coinReject, credit, busy
   );

   modport slave (
      input  fiveRupees, tenRupees, twentyFiveRupees, cancel, dispenseDone, changeAck,
      output dispenseReq, changeReq, coinReject, credit, busy
   );
endinterface

// File: rtl/vend_controller.sv
// Vending sequencer: collects coin credit, dispenses at PRICE, pays out excess or
// refunds in 5-rupee coins, and rejects coins it cannot take.
module vend_controller #(
   parameter int PRICE      = 25,
   parameter int MAX_CREDIT = 45,
   parameter int CREDIT_W   = 6,
   parameter int TIMEOUT    = 1000,
   parameter int TMR_W      = 10
) (
   input logic              clock,
   input logic              reset,
   vend_controller_if.slave bus
);

   typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

   localparam logic [CREDIT_W:0]   PRICE_W   = (CREDIT_W+1)'(PRICE);
   localparam logic [CREDIT_W:0]   MAX_W     = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [CREDIT_W:0]   COIN_5    = (CREDIT_W+1)'(5);
   localparam logic [CREDIT_W:0]   COIN_10   = (CREDIT_W+1)'(10);
   localparam logic [CREDIT_W:0]   COIN_25   = (CREDIT_W+1)'(25);
   localparam logic [CREDIT_W-1:0] CHANGE_5  = CREDIT_W'(5);
   localparam logic [TMR_W-1:0]    TMR_LAST  = TMR_W'(TIMEOUT-1);

   state_t              state;
   logic [CREDIT_W-1:0] credit_q;
   logic [TMR_W-1:0]    timer;
   logic                dispense_req;
   logic                change_req;
   logic                coin_reject;
   logic                busy_q;

   logic [1:0]          coin_count;
   logic [CREDIT_W:0]   coin_value;
   logic [CREDIT_W:0]   sum;
   logic [CREDIT_W:0]   remainder;
   logic                accept;
   logic                reject;

   // Arithmetic is one bit wider than credit so the MAX_CREDIT test sees true overflow.
   always_comb begin
      coin_count = 2'(bus.fiveRupees) + 2'(bus.tenRupees) + 2'(bus.twentyFiveRupees);
      coin_value = '0;
      if (bus.fiveRupees)
         coin_value = COIN_5;
      else if (bus.tenRupees)
         coin_value = COIN_10;
      else if (bus.twentyFiveRupees)
         coin_value = COIN_25;
      sum       = {1'b0, credit_q} + coin_value;
      remainder = {1'b0, credit_q} - PRICE_W;
      accept    = (coin_count == 2'd1) && !bus.cancel &&
                  (state == IDLE || state == COLLECT) && (sum <= MAX_W);
      reject    = (coin_count > 2'd1) || ((coin_count == 2'd1) && !accept);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state        <= IDLE;
         credit_q     <= '0;
         timer        <= '0;
         dispense_req <= 1'b0;
         change_req   <= 1'b0;
         coin_reject  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         coin_reject <= reject;
         case (state)
            IDLE: begin
               timer <= '0;
               if (accept) begin
                  credit_q <= sum[CREDIT_W-1:0];
                  if (sum >= PRICE_W) begin
                     state        <= DISPENSE;
                     dispense_req <= 1'b1;
                     busy_q       <= 1'b1;
                  end else begin
                     state <= COLLECT;
                  end
               end
            end

            COLLECT: begin
               if (accept) begin
                  credit_q <= sum[CREDIT_W-1:0];
                  timer    <= '0;
                  if (sum >= PRICE_W) begin
                     state        <= DISPENSE;
                     dispense_req <= 1'b1;
                     busy_q       <= 1'b1;
                  end
               end else if (bus.cancel || timer == TMR_LAST) begin
                  state      <= CHANGE;
                  change_req <= (credit_q != '0);
                  busy_q     <= 1'b1;
                  timer      <= '0;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end

            DISPENSE: begin
               if (bus.dispenseDone) begin
                  credit_q     <= remainder[CREDIT_W-1:0];
                  dispense_req <= 1'b0;
                  if (remainder != '0) begin
                     state      <= CHANGE;
                     change_req <= 1'b1;
                  end else begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end
               end
            end

            CHANGE: begin
               // Credit is always a multiple of 5, so the last ack lands exactly on zero.
               if (change_req && bus.changeAck) begin
                  if (credit_q > CHANGE_5) begin
                     credit_q <= credit_q - CHANGE_5;
                  end else begin
                     credit_q   <= '0;
                     change_req <= 1'b0;
                     state      <= IDLE;
                     busy_q     <= 1'b0;
                  end
               end else if (!change_req) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.dispenseReq = dispense_req;
   assign bus.changeReq   = change_req;
   assign bus.coinReject  = coin_reject;
   assign bus.credit      = credit_q;
   assign bus.busy        = busy_q;

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Top-level sequencer for the coin-operated vending path. Accumulates coin credit, triggers the dispense mechanism once credit reaches PRICE, then returns any excess as 5-rupee change coins.
- Also handles refunds on cancel or inactivity timeout, and rejects coins that cannot be accepted.
- Sits between the coin acceptor (single-cycle coin pulses) and two handshaked actuators: the dispense motor and the change hopper.

Parameters:
- PRICE, 25, product price in rupees; must be a multiple of 5 and at most MAX_CREDIT.
- MAX_CREDIT, 45, highest credit accepted; must be a multiple of 5.
- CREDIT_W, 6, credit register width; must satisfy 2^CREDIT_W > MAX_CREDIT.
- TIMEOUT, 1000, idle cycles in COLLECT before an automatic refund; must be at least 1.
- TMR_W, 10, timeout counter width; must satisfy 2^TMR_W > TIMEOUT.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; 0 = reset, sampled on the rising edge of clock.
- fiveRupees  input  1  single-cycle pulse, one 5-rupee coin inserted.
- tenRupees  input  1  single-cycle pulse, one 10-rupee coin inserted.
- twentyFiveRupees  input  1  single-cycle pulse, one 25-rupee coin inserted.
- cancel  input  1  single-cycle pulse, user requests a refund.
- dispenseDone  input  1  motor acknowledge; valid only while dispenseReq=1.
- changeAck  input  1  hopper acknowledge; one 5-rupee coin ejected per cycle sampled high while changeReq=1.
- dispenseReq  output  1  level request to the motor.
- changeReq  output  1  level request to the hopper.
- coinReject  output  1  one-cycle pulse, the inserted coin is diverted to the return chute.
- credit  output  CREDIT_W  current credit in rupees.
- busy  output  1  high in DISPENSE and CHANGE.

Behaviour:
- All outputs are registered.
- Reset (reset=0 at an edge): state=IDLE, credit=0, timer=0, all outputs 0. Reset wins over every other input, including mid-dispense and mid-change; an in-flight handshake is abandoned.
- States: IDLE, COLLECT, DISPENSE, CHANGE.
- Coin value v: 5, 10 or 25.
  - If more than one coin line is high in the same cycle, all of those coins are rejected.
- Coin acceptance, in IDLE or COLLECT with cancel=0 and exactly one coin line high:
  - If credit+v <= MAX_CREDIT: credit <= credit+v at that edge and timer <= 0.
  - Otherwise: credit is unchanged and coinReject=1 in the following cycle.
- Coins arriving in DISPENSE or CHANGE, or in the same cycle as cancel, are rejected: coinReject pulses for one cycle, credit is unchanged.
- IDLE:
  - Accepted coin with credit+v < PRICE -> COLLECT.
  - Accepted coin with credit+v >= PRICE -> DISPENSE.
  - cancel is ignored.
- COLLECT:
  - Accepted coin reaching PRICE -> DISPENSE.
  - cancel -> CHANGE (full refund).
  - Otherwise timer increments each cycle; when timer == TIMEOUT-1 -> CHANGE (refund).
- DISPENSE:
  - dispenseReq=1 from the first cycle in state.
  - On an edge with dispenseDone=1: credit <= credit-PRICE and dispenseReq=0 in the next cycle. Next state is CHANGE if the remainder is greater than 0, else IDLE.
  - cancel is ignored.
- CHANGE:
  - changeReq=1 while credit > 0.
  - Each edge with changeAck=1: credit <= credit-5.
  - On the ack that takes credit to 0: changeReq=0 in the next cycle and state -> IDLE.
  - cancel is ignored.
  - Credit never underflows; changeAck while changeReq=0 is ignored.
- dispenseDone outside DISPENSE is ignored.
- Latency:
  - Coin edge to credit update: 1 cycle.
  - Price reached to dispenseReq high: 1 cycle.
  - Last changeAck to IDLE (busy=0): 1 cycle.
- credit width: all arithmetic is done at CREDIT_W+1 bits, and the compare against MAX_CREDIT is done before writeback, so credit never wraps.

Test Plan:
- Reset, then 5, 10, 10 pulses on separate cycles -> credit 5, 15, 25; dispenseReq rises 1 cycle after the third coin; dispenseDone after 3 cycles -> credit=0, IDLE, changeReq never asserted.
- 10, 10, 25 -> the 25 pushes credit to 45; DISPENSE; after done, credit=20; changeReq held for 4 changeAck cycles (credit 15, 10, 5, 0), then IDLE.
- 10 then cancel -> CHANGE, 2 acks return 10, credit=0; a 5-rupee coin sent during CHANGE -> coinReject pulse, credit unchanged.
- fiveRupees and tenRupees high in the same cycle in IDLE -> coinReject=1, credit stays 0; then coin and cancel in the same cycle in COLLECT -> coin rejected, refund starts.
- 5 then no activity for TIMEOUT cycles -> CHANGE entered exactly on cycle TIMEOUT, 1 ack, IDLE; a coin at cycle TIMEOUT-2 restarts the timer.
- Assert reset=0 during DISPENSE with dispenseReq=1 -> next cycle all outputs 0, credit=0, IDLE; dispenseDone arriving afterwards has no effect.
